// File: rtl/fft_pkg.sv
// fft_pkg: transform geometry and peak-search defaults shared by the FFT slice
// (fft_peak_detect, FFT_Control, FIFO_Control).
package fft_pkg;

   localparam int N_FFT      = 1024;
   localparam int IDX_W      = 16;
   localparam int IN_W       = 32;
   localparam int MAG_W      = IN_W + 1;
   localparam int BIN_LO_DEF = 1;
   localparam int BIN_HI_DEF = 511;

   typedef enum logic {
      FR_IDLE,
      FR_RUN
   } frame_state_t;

endpackage

// File: rtl/fft_mag_approx.sv
// fft_mag_approx: 3-stage magnitude estimate (saturating abs, max/min, mx + mn/4)
// with a valid/idx/last sideband carried alongside the data.
module fft_mag_approx #(
   parameter int N_FFT = fft_pkg::N_FFT,
   parameter int IDX_W = fft_pkg::IDX_W,
   parameter int IN_W  = fft_pkg::IN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             beat_valid,
   input  logic [IN_W-1:0]  beat_re,
   input  logic [IN_W-1:0]  beat_im,
   input  logic [IDX_W-1:0] beat_idx,
   output logic             mag_valid,
   output logic [IN_W:0]    mag,
   output logic [IDX_W-1:0] mag_idx,
   output logic             mag_last
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FFT - 1);
   localparam logic [IN_W-1:0]  POS_MAX  = {1'b0, {(IN_W-1){1'b1}}};

   logic             s1_valid, s1_last;
   logic [IN_W-1:0]  s1_re, s1_im;
   logic [IDX_W-1:0] s1_idx;
   logic             s2_valid, s2_last;
   logic [IN_W-1:0]  s2_mx, s2_mn;
   logic [IDX_W-1:0] s2_idx;

   // The most negative value has no positive twin; clamp it to the largest positive.
   function automatic logic [IN_W-1:0] sat_abs(input logic [IN_W-1:0] x);
      if (!x[IN_W-1])
         return x;
      else if (x == ~POS_MAX)
         return POS_MAX;
      else
         return -x;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_re     <= '0;
         s1_im     <= '0;
         s1_idx    <= '0;
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         s2_mx     <= '0;
         s2_mn     <= '0;
         s2_idx    <= '0;
         mag_valid <= 1'b0;
         mag_last  <= 1'b0;
         mag       <= '0;
         mag_idx   <= '0;
      end else begin
         s1_valid  <= beat_valid;
         s1_re     <= sat_abs(beat_re);
         s1_im     <= sat_abs(beat_im);
         s1_idx    <= beat_idx;
         s1_last   <= (beat_idx == LAST_IDX);

         s2_valid  <= s1_valid;
         s2_mx     <= (s1_re >= s1_im) ? s1_re : s1_im;
         s2_mn     <= (s1_re >= s1_im) ? s1_im : s1_re;
         s2_idx    <= s1_idx;
         s2_last   <= s1_last;

         mag_valid <= s2_valid;
         mag       <= {1'b0, s2_mx} + {3'b000, s2_mn[IN_W-1:2]};
         mag_idx   <= s2_idx;
         mag_last  <= s2_last;
      end
   end

endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-frame peak search over the FFT beat stream; one result per frame.
// Define PEAK_FRAME_CHECK_EN to enable the bin-index continuity check (frame_err).
module fft_peak_detect #(
   parameter int N_FFT  = fft_pkg::N_FFT,
   parameter int IDX_W  = fft_pkg::IDX_W,
   parameter int IN_W   = fft_pkg::IN_W,
   parameter int BIN_LO = fft_pkg::BIN_LO_DEF,
   parameter int BIN_HI = fft_pkg::BIN_HI_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             data_valid,
   input  logic [IN_W-1:0]  data_re,
   input  logic [IN_W-1:0]  data_im,
   input  logic [IDX_W-1:0] data_idx,
   output logic             peak_valid,
   output logic [IDX_W-1:0] peak_bin,
   output logic [IN_W:0]    peak_mag,
   output logic             frame_err
);

   import fft_pkg::*;

   localparam logic [IDX_W-1:0] WIN_LO = IDX_W'(BIN_LO);
   localparam logic [IDX_W-1:0] WIN_HI = IDX_W'(BIN_HI);

   logic             mag_valid, mag_last;
   logic [IN_W:0]    mag;
   logic [IDX_W-1:0] mag_idx;

   frame_state_t     state;
   logic             cur_have;
   logic [IDX_W-1:0] cur_bin;
   logic [IN_W:0]    cur_max;
`ifdef PEAK_FRAME_CHECK_EN
   logic [IDX_W-1:0] exp_idx;
`endif

   logic             is_first, in_win, base_have, take, nx_have, seq_err, accept;
   logic [IDX_W-1:0] nx_bin;
   logic [IN_W:0]    nx_max;

   fft_mag_approx #(
      .N_FFT (N_FFT),
      .IDX_W (IDX_W),
      .IN_W  (IN_W)
   ) u_mag (
      .clk        (clk),
      .rst_n      (rst_n),
      .beat_valid (data_valid),
      .beat_re    (data_re),
      .beat_im    (data_im),
      .beat_idx   (data_idx),
      .mag_valid  (mag_valid),
      .mag        (mag),
      .mag_idx    (mag_idx),
      .mag_last   (mag_last)
   );

   // Running max including the current beat; idx 0 folds in on top of a cleared state.
   always_comb begin
      is_first  = (mag_idx == '0);
      in_win    = (mag_idx >= WIN_LO) && (mag_idx <= WIN_HI);
      base_have = is_first ? 1'b0 : cur_have;
      take      = in_win && (!base_have || (mag > cur_max));
      nx_have   = base_have | take;
      nx_bin    = take ? mag_idx : cur_bin;
      nx_max    = take ? mag : cur_max;
`ifdef PEAK_FRAME_CHECK_EN
      seq_err   = (state == FR_RUN) && (mag_idx != exp_idx);
`else
      seq_err   = 1'b0;
`endif
      accept    = is_first || ((state == FR_RUN) && !seq_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FR_IDLE;
         cur_have   <= 1'b0;
         cur_bin    <= '0;
         cur_max    <= '0;
`ifdef PEAK_FRAME_CHECK_EN
         exp_idx    <= '0;
`endif
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_mag   <= '0;
         frame_err  <= 1'b0;
      end else begin
         peak_valid <= 1'b0;
         frame_err  <= mag_valid && seq_err;
         if (mag_valid) begin
            if (accept) begin
               if (mag_last) begin
                  peak_valid <= 1'b1;
                  peak_bin   <= nx_have ? nx_bin : WIN_LO;
                  peak_mag   <= nx_have ? nx_max : '0;
                  state      <= FR_IDLE;
                  cur_have   <= 1'b0;
               end else begin
                  state      <= FR_RUN;
                  cur_have   <= nx_have;
                  cur_bin    <= nx_bin;
                  cur_max    <= nx_max;
               end
`ifdef PEAK_FRAME_CHECK_EN
               exp_idx <= mag_idx + 1'b1;
`endif
            end else if (seq_err) begin
               state    <= FR_IDLE;
               cur_have <= 1'b0;
            end
         end
      end
   end

endmodule
